// File: rtl/sprite_load_scheduler.sv
// Hands the shared sprite ROM to one renderer at a time during horizontal blanking,
// in round-robin order, with a fixed-length load slot per grant.
module sprite_load_scheduler #(
    parameter int N_SPR     = 4,
    parameter int ADDR_W    = 4,
    parameter int WIN_START = 696,
    parameter int WIN_END   = 800,
    parameter int SLOT_LEN  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [15:0]               hpos,
    input  logic [N_SPR-1:0]          req,
    input  logic [N_SPR*ADDR_W-1:0]   addr_in,
    output logic [ADDR_W-1:0]         rom_addr,
    output logic [N_SPR-1:0]          load,
    output logic                      busy,
    output logic                      overrun,
    output logic [N_SPR-1:0]          missed,
    output logic [1:0]                o_dbg_state
);

    localparam int PTR_W = $clog2(N_SPR);
    localparam int CNT_W = $clog2(SLOT_LEN) + 1;

    // Handshake: req is sampled only on the cycle hpos == WIN_START; load is a
    // one-hot strobe held for SLOT_LEN cycles while rom_addr is valid for that renderer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        SLOT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [N_SPR-1:0] r_pending;
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] r_winner;
    logic [CNT_W-1:0] r_cnt;

    logic             w_found;
    logic [PTR_W-1:0] w_winner;
    logic [15:0]      w_slot_end;
    logic             w_fits;
    logic [PTR_W-1:0] w_next_ptr;

    // Scan offsets high to low so the smallest offset from rr_ptr wins.
    always_comb begin
        int idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = 0;
        for (int k = N_SPR - 1; k >= 0; k--) begin
            idx = (int'(r_rr_ptr) + k) % N_SPR;
            if (r_pending[idx]) begin
                w_found  = 1'b1;
                w_winner = PTR_W'(idx);
            end
        end
    end

    assign w_slot_end  = hpos + 16'(1 + SLOT_LEN);
    assign w_fits      = (w_slot_end <= 16'(WIN_END));
    assign w_next_ptr  = (r_winner == PTR_W'(N_SPR - 1)) ? '0 : r_winner + 1'b1;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_rr_ptr  <= '0;
            r_winner  <= '0;
            r_cnt     <= '0;
            rom_addr  <= '0;
            load      <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            missed    <= '0;
        end else begin
            overrun <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (hpos == 16'(WIN_START)) begin
                        r_pending <= req;
                        missed    <= '0;
                        r_state   <= ARB;
                    end
                end
                ARB: begin
                    if (w_found && w_fits) begin
                        load     <= N_SPR'(1) << w_winner;
                        rom_addr <= addr_in[int'(w_winner)*ADDR_W +: ADDR_W];
                        busy     <= 1'b1;
                        r_cnt    <= '0;
                        r_winner <= w_winner;
                        r_state  <= SLOT;
                    end else begin
                        if (|r_pending) begin
                            overrun <= 1'b1;
                            missed  <= r_pending;
                        end
                        r_pending <= '0;
                        r_state   <= DONE;
                    end
                end
                SLOT: begin
                    if (r_cnt == CNT_W'(SLOT_LEN - 1)) begin
                        load                <= '0;
                        busy                <= 1'b0;
                        r_pending[r_winner] <= 1'b0;
                        r_rr_ptr            <= w_next_ptr;
                        r_state             <= ARB;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_load_scheduler.sv
// Bench for sprite_load_scheduler: transaction-level round-robin model feeding a grant
// queue, a negedge monitor for slot timing, and a short-window instance for overrun.
module tb_sprite_load_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] hpos = 16'd0;
    logic [3:0]  req = 4'd0;
    logic [15:0] addr_in = 16'd0;

    logic [3:0]  rom_addr, load, missed;
    logic        busy, overrun;
    logic [1:0]  dbg_state;

    logic [3:0]  b_rom_addr, b_load, b_missed;
    logic        b_busy, b_overrun;
    logic [1:0]  b_dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int n_grants = 0;
    int n_ovr = 0;

    // {start hpos[15:0], renderer[1:0], rom address[3:0]}
    logic [21:0] exp_q[$];
    logic [3:0]  miss_q[$];
    int          m_rr = 0;
    logic        mon_en = 1'b0;
    logic [3:0]  mon_prev = 4'd0;
    logic [3:0]  mon_addr = 4'd0;
    int          mon_len = 0;
    logic [3:0]  last_grant = 4'd0;

    always #5 clk = ~clk;

    sprite_load_scheduler #(.N_SPR(4), .ADDR_W(4), .WIN_START(696), .WIN_END(800), .SLOT_LEN(4)) dut (
        .clk(clk), .reset(reset), .hpos(hpos), .req(req), .addr_in(addr_in),
        .rom_addr(rom_addr), .load(load), .busy(busy), .overrun(overrun),
        .missed(missed), .o_dbg_state(dbg_state)
    );

    // 707 leaves room for exactly two slots (ARB at 697 and 702).
    sprite_load_scheduler #(.N_SPR(4), .ADDR_W(4), .WIN_START(696), .WIN_END(707), .SLOT_LEN(4)) dut_short (
        .clk(clk), .reset(reset), .hpos(hpos), .req(req), .addr_in(addr_in),
        .rom_addr(b_rom_addr), .load(b_load), .busy(b_busy), .overrun(b_overrun),
        .missed(b_missed), .o_dbg_state(b_dbg_state)
    );

    always @(negedge clk) begin
        if (!mon_en) begin
            mon_prev = 4'd0;
            mon_len  = 0;
        end else begin
            if (load !== 4'd0 || busy !== 1'b0) begin
                n_checks++;
                if (busy !== (load != 4'd0)) begin
                    n_errors++;
                    $display("FAIL busy_vs_load hpos=%0d busy=%b load=%b", hpos, busy, load);
                end
            end
            if (load !== 4'd0) begin
                n_checks++;
                if (!$onehot(load) || hpos < 16'd696 || hpos >= 16'd800) begin
                    n_errors++;
                    $display("FAIL load_window hpos=%0d load=%b (need one-hot inside 696..799)", hpos, load);
                end
                if (mon_prev == 4'd0) begin
                    n_checks++;
                    n_grants++;
                    last_grant = load;
                    mon_len    = 1;
                    mon_addr   = rom_addr;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL unexpected_grant hpos=%0d load=%b", hpos, load);
                    end else begin
                        logic [21:0] e;
                        logic [3:0]  exp_ld;
                        e = exp_q.pop_front();
                        exp_ld = 4'd1 << e[5:4];
                        if (hpos !== e[21:6] || load !== exp_ld || rom_addr !== e[3:0]) begin
                            n_errors++;
                            $display("FAIL grant got hpos=%0d load=%b addr=%0d need hpos=%0d load=%b addr=%0d",
                                     hpos, load, rom_addr, e[21:6], exp_ld, e[3:0]);
                        end
                    end
                end else begin
                    n_checks++;
                    mon_len++;
                    if (load !== mon_prev || rom_addr !== mon_addr) begin
                        n_errors++;
                        $display("FAIL slot_stable hpos=%0d load=%b addr=%0d need load=%b addr=%0d",
                                 hpos, load, rom_addr, mon_prev, mon_addr);
                    end
                end
            end else if (mon_prev != 4'd0) begin
                n_checks++;
                if (mon_len != 4) begin
                    n_errors++;
                    $display("FAIL slot_length hpos=%0d got %0d cycles need 4", hpos, mon_len);
                end
            end
            if (overrun === 1'b1) begin
                n_checks++;
                n_ovr++;
                if (miss_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_overrun hpos=%0d missed=%b", hpos, missed);
                end else begin
                    logic [3:0] em;
                    em = miss_q.pop_front();
                    if (missed !== em) begin
                        n_errors++;
                        $display("FAIL missed got %b need %b", missed, em);
                    end
                end
            end
            mon_prev = load;
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        hpos  = 16'd0;
        req   = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        m_rr  = 0;
        exp_q.delete();
        miss_q.delete();
    endtask

    // One line: model predicts grants from the req seen at hpos 696, then hpos sweeps 694..805.
    task automatic run_line(input logic [3:0] rq, input logic [3:0] rq_late, input logic [15:0] ad);
        logic [3:0] pend;
        int h, w, idx;
        pend = rq;
        h = 697;
        while (pend != 4'd0 && h + 1 + 4 <= 800) begin
            w = -1;
            for (int k = 0; k < 4; k++) begin
                idx = (m_rr + k) % 4;
                if (w < 0 && pend[idx]) w = idx;
            end
            exp_q.push_back({16'(h + 1), 2'(w), ad[w*4 +: 4]});
            pend[w] = 1'b0;
            m_rr = (w + 1) % 4;
            h += 5;
        end
        if (pend != 4'd0) miss_q.push_back(pend);
        addr_in = ad;
        for (int hp = 694; hp <= 805; hp++) begin
            hpos = 16'(hp);
            req  = (hp <= 696) ? rq : rq_late;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (exp_q.size() != 0 || miss_q.size() != 0) begin
            n_errors++;
            $display("FAIL line_drain grants_left=%0d overruns_left=%0d need 0", exp_q.size(), miss_q.size());
            exp_q.delete();
            miss_q.delete();
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks += 6;
        if (load !== 4'd0)     begin n_errors++; $display("FAIL reset_load got %b need 0000", load); end
        if (rom_addr !== 4'd0) begin n_errors++; $display("FAIL reset_rom_addr got %0d need 0", rom_addr); end
        if (busy !== 1'b0)     begin n_errors++; $display("FAIL reset_busy got %b need 0", busy); end
        if (overrun !== 1'b0)  begin n_errors++; $display("FAIL reset_overrun got %b need 0", overrun); end
        if (missed !== 4'd0)   begin n_errors++; $display("FAIL reset_missed got %b need 0000", missed); end
        if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL reset_state got %0d need 0", dbg_state); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_two_grants();
        int g0, o0;
        g0 = n_grants;
        o0 = n_ovr;
        mon_en = 1'b1;
        run_line(4'b0101, 4'b0101, 16'h0903);
        n_checks += 3;
        if (n_grants - g0 != 2) begin n_errors++; $display("FAIL two_grants_count got %0d need 2", n_grants - g0); end
        if (n_ovr != o0) begin n_errors++; $display("FAIL two_grants_overrun got %0d need 0", n_ovr - o0); end
        if (last_grant !== 4'b0100) begin n_errors++; $display("FAIL two_grants_last got %b need 0100", last_grant); end
    endtask

    task automatic test_late_req();
        int g0, o0;
        g0 = n_grants;
        o0 = n_ovr;
        run_line(4'b0000, 4'b1111, 16'hFFFF);
        n_checks += 2;
        if (n_grants != g0) begin n_errors++; $display("FAIL late_req_grants got %0d need 0", n_grants - g0); end
        if (n_ovr != o0) begin n_errors++; $display("FAIL late_req_overrun got %0d need 0", n_ovr - o0); end
    endtask

    task automatic test_overrun();
        logic [15:0] ad;
        logic [3:0]  exp_ld, exp_miss, prev_miss, exp_addr;
        int g0, g1;
        mon_en = 1'b0;
        do_reset();
        ad = 16'h7521;
        prev_miss = 4'b0000;
        addr_in = ad;
        for (int line = 0; line < 2; line++) begin
            g0 = (line == 0) ? 0 : 2;
            g1 = g0 + 1;
            exp_miss = (line == 0) ? 4'b1100 : 4'b0011;
            for (int hp = 694; hp <= 712; hp++) begin
                hpos = 16'(hp);
                req  = 4'b1111;
                @(negedge clk);
                exp_ld = 4'd0;
                exp_addr = 4'd0;
                if (hp >= 698 && hp <= 701) begin exp_ld = 4'd1 << g0; exp_addr = ad[g0*4 +: 4]; end
                if (hp >= 703 && hp <= 706) begin exp_ld = 4'd1 << g1; exp_addr = ad[g1*4 +: 4]; end
                n_checks += 3;
                if (b_load !== exp_ld || (exp_ld != 4'd0 && b_rom_addr !== exp_addr)) begin
                    n_errors++;
                    $display("FAIL short_load line=%0d hpos=%0d got load=%b addr=%0d need load=%b addr=%0d",
                             line, hp, b_load, b_rom_addr, exp_ld, exp_addr);
                end
                if (b_overrun !== (hp == 708)) begin
                    n_errors++;
                    $display("FAIL short_overrun line=%0d hpos=%0d got %b need %b", line, hp, b_overrun, hp == 708);
                end
                if (b_missed !== ((hp >= 708) ? exp_miss : (hp <= 696) ? prev_miss : 4'b0000)) begin
                    n_errors++;
                    $display("FAIL short_missed line=%0d hpos=%0d got %b", line, hp, b_missed);
                end
                @(posedge clk);
                #1;
            end
            prev_miss = exp_miss;
        end
    endtask

    task automatic test_reset_mid_slot();
        int g0;
        mon_en = 1'b0;
        do_reset();
        req = 4'b0001;
        addr_in = 16'h000A;
        for (int hp = 694; hp <= 699; hp++) begin
            hpos = 16'(hp);
            if (hp == 699) reset = 1'b0;
            @(negedge clk);
            if (hp == 698) begin
                n_checks++;
                if (load !== 4'b0001 || busy !== 1'b1 || rom_addr !== 4'hA) begin
                    n_errors++;
                    $display("FAIL mid_slot_active got load=%b busy=%b addr=%0d need 0001 1 10", load, busy, rom_addr);
                end
            end
            @(posedge clk);
            #1;
        end
        hpos = 16'd700;
        @(negedge clk);
        n_checks++;
        if (load !== 4'd0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_slot_reset got load=%b busy=%b need 0000 0", load, busy);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_rr = 0;
        exp_q.delete();
        miss_q.delete();
        mon_en = 1'b1;
        g0 = n_grants;
        run_line(4'b0001, 4'b0001, 16'h000A);
        n_checks++;
        if (n_grants - g0 != 1 || last_grant !== 4'b0001) begin
            n_errors++;
            $display("FAIL after_reset_grant got count=%0d load=%b need 1 0001", n_grants - g0, last_grant);
        end
    endtask

    task automatic test_random();
        mon_en = 1'b1;
        for (int l = 0; l < 500; l++) begin
            run_line(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 16'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_two_grants();
        test_late_req();
        test_overrun();
        test_reset_mid_slot();
        test_random();
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
